bram_stream_loader: RTL and testbench

- Upstream stage of the max-value engine: accepts a valid/ready stream of 32-bit words and writes them into consecutive BRAM words through the BRAM's PL-side port, starting at byte address 0.
- Started and acknowledged by the PS through a control/status register pair, using the same start/done/acknowledge handshake as the max-value block.
- On completion, the PS reads the word count and starts the downstream max-value pass.

---
 rtl/bram_loader_pkg.sv | 16 +
 rtl/bram_loader_csum.sv | 25 ++
 rtl/bram_stream_loader.sv | 113 +++++++++++
 tb/tb_bram_stream_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_loader_pkg.sv
// Shared encodings for the BRAM stream loader: FSM states, status and control bit positions.
package bram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int STAT_DONE    = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_CNT_LSB = 16;
  localparam int CTRL_START   = 0;

endpackage

// File: rtl/bram_loader_csum.sv
// Running modulo-2^32 sum of accepted stream words; built only when
// BRAM_STREAM_LOADER_CHECKSUM_EN is defined.
module bram_loader_csum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        add,
  input  logic [31:0] data,
  output logic [31:0] sum
);

  // Accumulator: cleared while the loader idles, adds each accepted word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= 32'h0;
    end else if (clear) begin
      sum <= 32'h0;
    end else if (add) begin
      sum <= sum + data;
    end else begin
      sum <= sum;
    end
  end

endmodule

// File: rtl/bram_stream_loader.sv
// Writes a valid/ready word stream into consecutive BRAM words under PS start/done control.
// Optional running checksum enabled by defining BRAM_STREAM_LOADER_CHECKSUM_EN.
module bram_stream_loader
  import bram_loader_pkg::*;
#(
  parameter  int DEPTH     = 2048,
  localparam int ADDRWIDTH = $clog2(DEPTH) + 2,
  localparam int CNTWIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          ps_control,
  output logic [31:0]          pl_status,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  output logic [ADDRWIDTH-1:0] bram_addr,
  output logic [31:0]          bram_wrdata,
  output logic [3:0]           bram_we,
  output logic [31:0]          checksum
);

  localparam logic [CNTWIDTH-1:0] CNT_ONE  = CNTWIDTH'(1);
  localparam logic [CNTWIDTH-1:0] CNT_FULL = CNTWIDTH'(DEPTH);

  state_t              state;
  logic [CNTWIDTH-1:0] count;
  logic                overflow;
  logic                start;
  logic                accept;
  logic [CNTWIDTH-1:0] count_inc;
  logic [31:0]         status;
  logic                unused_ctrl;

  assign start       = ps_control[CTRL_START];
  assign unused_ctrl = ^ps_control[31:1];
  assign in_ready    = (state == LOAD);
  assign accept      = in_valid && in_ready;
  assign count_inc   = count + CNT_ONE;

  // Control FSM, word counter and the registered BRAM write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= {CNTWIDTH{1'b0}};
      overflow    <= 1'b0;
      bram_we     <= 4'h0;
      bram_addr   <= {ADDRWIDTH{1'b0}};
      bram_wrdata <= 32'h0;
    end else begin
      bram_we <= 4'h0;
      // A word accepted in the abort cycle is still written, never dropped.
      if (accept) begin
        bram_we     <= 4'hf;
        bram_addr   <= {count[CNTWIDTH-2:0], 2'b00};
        bram_wrdata <= in_data;
        count       <= count_inc;
      end
      case (state)
        IDLE: begin
          count    <= {CNTWIDTH{1'b0}};
          overflow <= 1'b0;
          if (start) state <= LOAD;
        end
        LOAD: begin
          if (!start) begin
            state <= IDLE;
          end else if (accept && in_last) begin
            state <= FLUSH;
          end else if (accept && (count_inc == CNT_FULL)) begin
            overflow <= 1'b1;
            state    <= FLUSH;
          end
        end
        FLUSH: state <= DONE;
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status word; count and overflow are masked during IDLE so a stale abort count never shows.
  always_comb begin
    status            = 32'h0;
    status[STAT_DONE] = (state == DONE);
    if (state != IDLE) begin
      status[STAT_OVF]                = overflow;
      status[STAT_CNT_LSB +: 16]      = 16'(count);
    end else begin
      status[STAT_OVF]                = 1'b0;
      status[STAT_CNT_LSB +: 16]      = 16'h0;
    end
  end

  assign pl_status = status;

`ifdef BRAM_STREAM_LOADER_CHECKSUM_EN
  bram_loader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .add   (accept),
    .data  (in_data),
    .sum   (checksum)
  );
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader: per-cycle reference model plus directed literal checks.
module tb_bram_stream_loader;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ps_control;
  logic [31:0] pl_status;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [12:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [3:0]  bram_we;
  logic [31:0] checksum;

  bram_stream_loader #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps_control  (ps_control),
    .pl_status   (pl_status),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .bram_addr   (bram_addr),
    .bram_wrdata (bram_wrdata),
    .bram_we     (bram_we),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 loading, 2 final write, 3 done.
  int          m_mode = 0;
  int          m_cnt  = 0;
  bit          m_ovf  = 1'b0;
  logic [31:0] m_sum  = 32'h0;
  bit          m_we   = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_data = 32'h0;
  bit          m_acc;

  assign m_acc = in_valid && (m_mode == 1);

  always @(posedge clk) begin
    if (!reset) begin
      m_mode <= 0; m_cnt <= 0; m_ovf <= 1'b0; m_sum <= 32'h0;
      m_we <= 1'b0; m_addr <= 32'h0; m_data <= 32'h0;
    end else begin
      m_we <= m_acc;
      if (m_acc) begin
        m_addr <= (m_cnt % DEPTH) * 4;
        m_data <= in_data;
      end
      if (m_mode == 0) begin
        m_cnt <= 0; m_ovf <= 1'b0; m_sum <= 32'h0;
        if (ps_control[0]) m_mode <= 1;
      end else if (m_mode == 1) begin
        if (m_acc) begin
          m_cnt <= m_cnt + 1;
          m_sum <= m_sum + in_data;
        end
        if (!ps_control[0]) m_mode <= 0;
        else if (m_acc && in_last) m_mode <= 2;
        else if (m_acc && (m_cnt + 1 == DEPTH)) begin
          m_ovf  <= 1'b1;
          m_mode <= 2;
        end
      end else if (m_mode == 2) begin
        m_mode <= 3;
      end else begin
        if (!ps_control[0]) m_mode <= 0;
      end
    end
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (m_mode == 3);
    if (m_mode != 0) begin
      s[1]     = m_ovf;
      s[31:16] = m_cnt[15:0];
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_csum();
`ifdef BRAM_STREAM_LOADER_CHECKSUM_EN
    return m_sum;
`else
    return 32'h0;
`endif
  endfunction

  int          wtotal    = 0;
  int          done_cnt  = 0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_data = 32'h0;

  // Compare process: every cycle against the model, and write capture.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'h0, in_ready}, {31'h0, m_mode == 1});
      chk("bram_we", {28'h0, bram_we}, m_we ? 32'hf : 32'h0);
      chk("bram_addr", {19'h0, bram_addr}, m_addr);
      chk("bram_wrdata", bram_wrdata, m_data);
      chk("pl_status", pl_status, exp_status());
      chk("checksum", checksum, exp_csum());
      if (bram_we == 4'hf) begin
        wtotal++;
        last_addr = {19'h0, bram_addr};
        last_data = bram_wrdata;
      end
      if (pl_status[0]) done_cnt++;
    end
  end

  function automatic logic [31:0] word_val(input int kind, input int i);
    return (kind == 0) ? 32'(10 * (i + 1)) : 32'(3 * i + 7);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int last_at, input bit bubbles, input int kind);
    int tries;
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        in_valid = 1'b0; in_data = 32'hdead_beef; in_last = 1'b1;
        tick();
      end
      in_valid = 1'b1;
      in_data  = word_val(kind, i);
      in_last  = (i + 1 == last_at);
      tries = 0;
      while (!in_ready && tries < 20) begin
        tick();
        tries++;
      end
      if (tries >= 20) begin
        chk("accept_timeout", 32'(tries), 32'h0);
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  int          w0;
  int          d0;
  logic [31:0] cs_big;

  initial begin
`ifdef BRAM_STREAM_LOADER_CHECKSUM_EN
    cs_big = 32'd6302720;
`else
    cs_big = 32'h0;
`endif
    reset = 1'b0; ps_control = 32'h0; in_valid = 1'b1; in_data = 32'h1234; in_last = 1'b0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_we", {28'h0, bram_we}, 32'h0);
    chk("rst_status", pl_status, 32'h0);
    chk("rst_csum", checksum, 32'h0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Five words, continuous valid.
    w0 = wtotal;
    ps_control = 32'h1;
    send(5, 5, 1'b0, 0);
    tick();
    chk("s5_status", pl_status, 32'h0005_0001);
    chk("s5_writes", 32'(wtotal - w0), 32'd5);
    chk("s5_last_addr", last_addr, 32'd16);
    chk("s5_last_data", last_data, 32'd50);
`ifdef BRAM_STREAM_LOADER_CHECKSUM_EN
    chk("s5_csum", checksum, 32'd150);
`else
    chk("s5_csum", checksum, 32'd0);
`endif
    ps_control = 32'h0;
    tick();
    chk("s5_idle_status", pl_status, 32'h0);

    // Same stream with bubbles between words.
    w0 = wtotal;
    ps_control = 32'h1;
    send(5, 5, 1'b1, 0);
    tick();
    chk("bub_status", pl_status, 32'h0005_0001);
    chk("bub_writes", 32'(wtotal - w0), 32'd5);
    chk("bub_last_addr", last_addr, 32'd16);
    ps_control = 32'h0;
    tick();

    // Overflow: 2048 words without last, word 2049 must stall.
    w0 = wtotal;
    ps_control = 32'h1;
    send(2048, 0, 1'b0, 1);
    in_valid = 1'b1; in_data = 32'habcd_0001; in_last = 1'b1;
    tick();
    chk("ovf_status", pl_status, 32'h0800_0003);
    chk("ovf_writes", 32'(wtotal - w0), 32'd2048);
    chk("ovf_last_addr", last_addr, 32'd8188);
    chk("ovf_last_data", last_data, 32'd6148);
    chk("ovf_csum", checksum, cs_big);
    repeat (3) begin
      tick();
      chk("ovf_stall", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    ps_control = 32'h0;
    tick();

    // Exact fill: last on word 2048.
    ps_control = 32'h1;
    send(2048, 2048, 1'b0, 1);
    tick();
    chk("fill_status", pl_status, 32'h0800_0001);
    chk("fill_csum", checksum, cs_big);
    ps_control = 32'h0;
    tick();

    // Abort after three words.
    w0 = wtotal; d0 = done_cnt;
    ps_control = 32'h1;
    send(3, 0, 1'b0, 0);
    ps_control = 32'h0;
    repeat (4) tick();
    chk("abort_writes", 32'(wtotal - w0), 32'd3);
    chk("abort_last_addr", last_addr, 32'd8);
    chk("abort_last_data", last_data, 32'd30);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_status", pl_status, 32'h0);

    // Reset pulsed mid-LOAD.
    ps_control = 32'h1;
    send(2, 0, 1'b0, 0);
    in_valid = 1'b1; in_data = 32'd99; reset = 1'b0;
    tick();
    chk("mrst_ready", {31'h0, in_ready}, 32'h0);
    chk("mrst_we", {28'h0, bram_we}, 32'h0);
    chk("mrst_addr", {19'h0, bram_addr}, 32'h0);
    chk("mrst_data", bram_wrdata, 32'h0);
    chk("mrst_status", pl_status, 32'h0);
    chk("mrst_csum", checksum, 32'h0);
    in_valid = 1'b0; reset = 1'b1; ps_control = 32'h0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
